// File: rtl/decode_stage_pkg.sv
// Shared types and decode helpers for the RV32 ID stage: encodings, control bundle,
// opcode constants, immediate extraction and the control decoder.
package decode_stage_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned REG_ID_W = 5;

  typedef logic [INST_W-1:0] instruction_type;

  typedef enum logic [2:0] {
    ENC_R = 3'd0,
    ENC_I = 3'd1,
    ENC_S = 3'd2,
    ENC_B = 3'd3,
    ENC_U = 3'd4,
    ENC_J = 3'd5
  } encoding_type;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_type;

  typedef struct packed {
    encoding_type encoding;
    alu_op_type   alu_op;
    logic         alu_src;
    logic         mem_read;
    logic         mem_write;
    logic         reg_write;
    logic         mem_to_reg;
    logic         is_branch;
  } control_type;

  typedef struct packed {
    control_type control;
    logic        illegal;
  } decode_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // 32-bit sign-extended immediate; B/J bit 0 is always zero, R yields zero
  function automatic logic [31:0] immediate_extension(input instruction_type inst,
                                                       input encoding_type enc);
    logic [31:0] imm;
    case (enc)
      ENC_I:   imm = {{20{inst[31]}}, inst[31:20]};
      ENC_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ENC_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ENC_U:   imm = {inst[31:12], 12'b0};
      ENC_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Unsupported opcode/funct3 combinations decode to an all-zero (bubble) control word
  function automatic decode_type decode_control(input instruction_type inst);
    decode_type d;
    logic [2:0] f3;
    d  = '0;
    f3 = inst[14:12];
    case (inst[6:0])
      OPC_OP: begin
        d.control.encoding  = ENC_R;
        d.control.reg_write = 1'b1;
        case (f3)
          3'b000:  d.control.alu_op = inst[30] ? ALU_SUB : ALU_ADD;
          3'b111:  d.control.alu_op = ALU_AND;
          3'b110:  d.control.alu_op = ALU_OR;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d.control.encoding  = ENC_I;
        d.control.alu_src   = 1'b1;
        d.control.reg_write = 1'b1;
        case (f3)
          3'b000:  d.control.alu_op = ALU_ADD;
          3'b111:  d.control.alu_op = ALU_AND;
          3'b110:  d.control.alu_op = ALU_OR;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.control.encoding   = ENC_I;
        d.control.alu_op     = ALU_ADD;
        d.control.alu_src    = 1'b1;
        d.control.mem_read   = 1'b1;
        d.control.reg_write  = 1'b1;
        d.control.mem_to_reg = 1'b1;
        d.illegal            = (f3 != 3'b010);
      end
      OPC_STORE: begin
        d.control.encoding  = ENC_S;
        d.control.alu_op    = ALU_ADD;
        d.control.alu_src   = 1'b1;
        d.control.mem_write = 1'b1;
        d.illegal           = (f3 != 3'b010);
      end
      OPC_BRANCH: begin
        d.control.encoding  = ENC_B;
        d.control.alu_op    = ALU_SUB;
        d.control.is_branch = 1'b1;
        d.illegal           = (f3 != 3'b000);
      end
      OPC_LUI: begin
        d.control.encoding  = ENC_U;
        d.control.alu_op    = ALU_ADD;
        d.control.alu_src   = 1'b1;
        d.control.reg_write = 1'b1;
      end
      OPC_JAL: begin
        d.control.encoding  = ENC_J;
        d.control.alu_op    = ALU_ADD;
        d.control.reg_write = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) d.control = '0;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Architectural register file: REG_COUNT x XLEN, two async read ports, one sync write port.
// x0 and ids beyond REG_COUNT always read zero.
module decode_register_file
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic [XLEN-1:0]     rd1,
  output logic [XLEN-1:0]     rd2,
  input  logic                write_en,
  input  logic [REG_ID_W-1:0] write_id,
  input  logic [XLEN-1:0]     write_data
);

  localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [REG_ID_W:0] REG_LIMIT = (REG_ID_W + 1)'(REG_COUNT);

  logic [XLEN-1:0] regs [REG_COUNT];

  function automatic logic id_valid(input logic [REG_ID_W-1:0] id);
    return (id != '0) && ({1'b0, id} < REG_LIMIT);
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (id_valid(rs1_id)) rd1 = regs[rs1_id[IDX_W-1:0]];
    if (id_valid(rs2_id)) rd2 = regs[rs2_id[IDX_W-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
    end else if (write_en && id_valid(write_id)) begin
      regs[write_id[IDX_W-1:0]] <= write_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: decodes an IF/ID word, reads operands with write-back bypass,
// and holds a refreshable ID/EX bundle under a valid/ready handshake.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  instruction_type     in_instruction,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [REG_ID_W-1:0] out_rs1_id,
  output logic [REG_ID_W-1:0] out_rs2_id,
  output logic [REG_ID_W-1:0] out_rd_id,
  output logic [XLEN-1:0]     out_data1,
  output logic [XLEN-1:0]     out_data2,
  output logic [XLEN-1:0]     out_immediate,
  output control_type         out_control,
  output logic                out_illegal,
  input  logic                wb_write_en,
  input  logic [REG_ID_W-1:0] wb_rd_id,
  input  logic [XLEN-1:0]     wb_data
);

  localparam logic [REG_ID_W:0] REG_LIMIT = (REG_ID_W + 1)'(REG_COUNT);

  decode_type          dec_c;
  encoding_type        enc_c;
  logic [REG_ID_W-1:0] rs1_c, rs2_c, rd_c;
  logic                illegal_c;
  control_type         control_c;
  logic [XLEN-1:0]     imm_c;
  logic [XLEN-1:0]     rf_data1, rf_data2;
  logic [XLEN-1:0]     data1_c, data2_c;
  logic                wb_we_c;
  logic                capture_c;

  function automatic logic id_in_range(input logic [REG_ID_W-1:0] id);
    return {1'b0, id} < REG_LIMIT;
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign capture_c = in_valid && in_ready;
  assign wb_we_c   = wb_write_en && (wb_rd_id != '0) && id_in_range(wb_rd_id);

  // Only fields the encoding actually uses are reported; the rest read as x0
  always_comb begin
    dec_c = decode_control(in_instruction);
    enc_c = dec_c.control.encoding;
    rs1_c = '0;
    rs2_c = '0;
    rd_c  = '0;
    if (!dec_c.illegal) begin
      if (enc_c inside {ENC_R, ENC_I, ENC_S, ENC_B}) rs1_c = in_instruction[19:15];
      if (enc_c inside {ENC_R, ENC_S, ENC_B})        rs2_c = in_instruction[24:20];
      if (enc_c inside {ENC_R, ENC_I, ENC_U, ENC_J}) rd_c  = in_instruction[11:7];
    end
    illegal_c = dec_c.illegal || !id_in_range(rs1_c) || !id_in_range(rs2_c)
                || !id_in_range(rd_c);
    control_c = illegal_c ? '0 : dec_c.control;
    imm_c     = XLEN'($signed(immediate_extension(in_instruction, enc_c)));
  end

  decode_register_file #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT)
  ) u_register_file (
    .clk        (clk),
    .reset      (reset),
    .rs1_id     (rs1_c),
    .rs2_id     (rs2_c),
    .rd1        (rf_data1),
    .rd2        (rf_data2),
    .write_en   (wb_we_c),
    .write_id   (wb_rd_id),
    .write_data (wb_data)
  );

  // Same-cycle write-back wins over the stale register file value
  always_comb begin
    data1_c = rf_data1;
    data2_c = rf_data2;
    if (wb_we_c && (wb_rd_id == rs1_c)) data1_c = wb_data;
    if (wb_we_c && (wb_rd_id == rs2_c)) data2_c = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_id    <= '0;
      out_rs2_id    <= '0;
      out_rd_id     <= '0;
      out_data1     <= '0;
      out_data2     <= '0;
      out_immediate <= '0;
      out_control   <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_c) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_id    <= rs1_c;
      out_rs2_id    <= rs2_c;
      out_rd_id     <= rd_c;
      out_data1     <= data1_c;
      out_data2     <= data2_c;
      out_immediate <= imm_c;
      out_control   <= control_c;
      out_illegal   <= illegal_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Held bundle tracks write-backs to its source registers
      if (wb_we_c && (wb_rd_id == out_rs1_id)) out_data1 <= wb_data;
      if (wb_we_c && (wb_rd_id == out_rs2_id)) out_data2 <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32 cases plus randomized handshake,
// flush and write-back traffic checked against a behavioural decode model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instruction = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1_id, out_rs2_id, out_rd_id;
  logic [31:0] out_data1, out_data2, out_immediate;
  control_type out_control;
  logic        out_illegal;
  logic        wb_write_en = 1'b0;
  logic [4:0]  wb_rd_id = '0;
  logic [31:0] wb_data = '0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    control_type ctl;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instruction (in_instruction),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_rs1_id     (out_rs1_id),
    .out_rs2_id     (out_rs2_id),
    .out_rd_id      (out_rd_id),
    .out_data1      (out_data1),
    .out_data2      (out_data2),
    .out_immediate  (out_immediate),
    .out_control    (out_control),
    .out_illegal    (out_illegal),
    .wb_write_en    (wb_write_en),
    .wb_rd_id       (wb_rd_id),
    .wb_data        (wb_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode computed from the instruction-set rules with integer arithmetic
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    logic [2:0] f3;
    logic bad, u1, u2, ud;
    int s;
    e.pc = pc; e.ctl = '0; e.illegal = 1'b0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    f3 = ins[14:12];
    bad = 1'b0; u1 = 1'b0; u2 = 1'b0; ud = 1'b0;
    case (ins[6:0])
      7'h33: begin
        e.ctl.encoding = ENC_R; e.ctl.reg_write = 1'b1; u1 = 1; u2 = 1; ud = 1;
        if (f3 == 3'd0) e.ctl.alu_op = ins[30] ? ALU_SUB : ALU_ADD;
        else if (f3 == 3'd7) e.ctl.alu_op = ALU_AND;
        else if (f3 == 3'd6) e.ctl.alu_op = ALU_OR;
        else bad = 1'b1;
      end
      7'h13: begin
        e.ctl.encoding = ENC_I; e.ctl.alu_src = 1'b1; e.ctl.reg_write = 1'b1; u1 = 1; ud = 1;
        if (f3 == 3'd0) e.ctl.alu_op = ALU_ADD;
        else if (f3 == 3'd7) e.ctl.alu_op = ALU_AND;
        else if (f3 == 3'd6) e.ctl.alu_op = ALU_OR;
        else bad = 1'b1;
      end
      7'h03: begin
        e.ctl.encoding = ENC_I; e.ctl.alu_src = 1'b1; e.ctl.mem_read = 1'b1;
        e.ctl.reg_write = 1'b1; e.ctl.mem_to_reg = 1'b1; u1 = 1; ud = 1;
        bad = (f3 != 3'd2);
      end
      7'h23: begin
        e.ctl.encoding = ENC_S; e.ctl.alu_src = 1'b1; e.ctl.mem_write = 1'b1; u1 = 1; u2 = 1;
        bad = (f3 != 3'd2);
      end
      7'h63: begin
        e.ctl.encoding = ENC_B; e.ctl.alu_op = ALU_SUB; e.ctl.is_branch = 1'b1; u1 = 1; u2 = 1;
        bad = (f3 != 3'd0);
      end
      7'h37: begin
        e.ctl.encoding = ENC_U; e.ctl.alu_src = 1'b1; e.ctl.reg_write = 1'b1; ud = 1;
      end
      7'h6F: begin
        e.ctl.encoding = ENC_J; e.ctl.reg_write = 1'b1; ud = 1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e.ctl = '0;
      e.illegal = 1'b1;
      return e;
    end
    if (u1) e.rs1 = ins[19:15];
    if (u2) e.rs2 = ins[24:20];
    if (ud) e.rd  = ins[11:7];
    case (e.ctl.encoding)
      ENC_I: s = int'($signed(ins)) >>> 20;
      ENC_S: s = ((int'($signed(ins)) >>> 25) <<< 5) | int'(ins[11:7]);
      ENC_B: s = ((int'($signed(ins)) >>> 31) <<< 12) | (int'(ins[7]) << 11)
                 | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
      ENC_U: s = int'(ins & 32'hFFFF_F000);
      ENC_J: s = ((int'($signed(ins)) >>> 31) <<< 20) | (int'(ins[19:12]) << 12)
                 | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
      default: s = 0;
    endcase
    e.imm = 32'(s);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k, j;
    logic [2:0] alu_f3;
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    j = $urandom_range(0, 4);
    alu_f3 = (j == 0) ? 3'd0 : (j == 1) ? 3'd7 : (j == 2) ? 3'd6 : 3'($urandom);
    k = $urandom_range(0, 8);
    case (k)
      0: begin r[6:0] = 7'h33; r[14:12] = alu_f3; end
      1: begin r[6:0] = 7'h13; r[14:12] = alu_f3; end
      2: begin r[6:0] = 7'h03; if (j < 4) r[14:12] = 3'd2; end
      3: begin r[6:0] = 7'h23; if (j < 4) r[14:12] = 3'd2; end
      4: begin r[6:0] = 7'h63; if (j < 4) r[14:12] = 3'd0; end
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h6F;
      default: ;
    endcase
    return r;
  endfunction

  // One clock of stimulus; expected bundle queued once the capture edge has passed
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic wbe,
                      input logic [4:0] wid, input logic [31:0] wd);
    logic cap;
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instruction = ins; out_ready = ordy; flush = fl;
    wb_write_en = wbe; wb_rd_id = wid; wb_data = wd;
    #1 cap = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    if (!reset && wbe && wid != 5'd0) mregs[wid] = wd;
    if (cap && !fl) sb.push_back(model(pc, ins));
  endtask

  // Monitor: compares the presented bundle every cycle, retires it on accept or flush
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'(|{out_illegal, out_pc, out_rs1_id, out_rs2_id, out_rd_id,
            out_data1, out_data2, out_immediate, out_control}), 64'd0);
      end else begin
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
          chk("pc", 64'(out_pc), 64'(sb[0].pc));
          chk("ids", 64'({out_rs1_id, out_rs2_id, out_rd_id}),
              64'({sb[0].rs1, sb[0].rs2, sb[0].rd}));
          chk("immediate", 64'(out_immediate), 64'(sb[0].imm));
          chk("control", 64'({out_control, out_illegal}), 64'({sb[0].ctl, sb[0].illegal}));
          chk("data1", 64'(out_data1), 64'(mregs[sb[0].rs1]));
          chk("data2", 64'(out_data2), 64'(mregs[sb[0].rs2]));
          if (flush || out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // addi x1,x0,-5
    step(1, 32'h100, 32'hFFB0_0093, 1, 0, 0, 0, 0);
    chk("addi_imm", 64'(out_immediate), 64'hFFFF_FFFB);
    chk("addi_ctl", 64'({out_control.alu_op, out_control.alu_src, out_control.reg_write}),
        64'({ALU_ADD, 1'b1, 1'b1}));

    // add x3,x1,x2 with same-cycle write-back of x1
    step(1, 32'h104, 32'h0020_81B3, 1, 0, 1, 5'd1, 32'h1234);
    chk("bypass_data1", 64'(out_data1), 64'h1234);

    // hold three cycles, write x2 in the middle
    step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0, 1, 5'd2, 32'hBEEF);
    step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("held_data2", 64'(out_data2), 64'hBEEF);
    chk("held_pc", 64'(out_pc), 64'h104);

    // flush together with a new input
    step(1, 32'h108, 32'h0020_81B3, 1, 1, 0, 0, 0);
    chk("flush_valid", 64'(out_valid), 64'd0);

    // jal x1,-4
    step(1, 32'h10C, 32'hFFDF_F0EF, 1, 0, 0, 0, 0);
    chk("jal_valid", 64'(out_valid), 64'd1);
    chk("jal_imm", 64'(out_immediate), 64'hFFFF_FFFC);
    chk("jal_enc", 64'(out_control.encoding), 64'(ENC_J));

    // unsupported opcode
    step(1, 32'h110, 32'h0000_007F, 1, 0, 0, 0, 0);
    chk("illegal_flag", 64'(out_illegal), 64'd1);
    chk("illegal_ctl", 64'(out_control), 64'd0);

    // randomized traffic
    pc = 32'h200;
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, pc, rand_inst(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom);
      pc += 32'd4;
    end

    // reset while a bundle is held
    step(1, 32'h300, 32'h0020_81B3, 0, 0, 1, 5'd1, 32'hAAAA_5555);
    step(0, 32'h0, 32'h0, 0, 0, 1, 5'd2, 32'h5555_AAAA);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_write_en = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    #1 chk("reset_drop", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(1, 32'h304, 32'h0020_81B3, 1, 0, 0, 0, 0);
    chk("post_reset_regs", 64'({out_data1, out_data2}), 64'd0);

    repeat (3) step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
